tone_mixer_pwm: RTL and testbench
=================================

Name: tone_mixer_pwm

Overview:
- Downstream consumer of the note-control stage's four voice outputs `freq1..freq4`. Each value is a half-period in clock cycles; 0 means the voice is silent.
- Generates one square-wave voice per input and sums the four voices into an unsigned sample.
- Drives a 1-bit PWM audio pin, with the duty cycle refreshed once per PWM period.

Parameters:
- FREQ_WIDTH, 12, width of each half-period input and each voice counter.
- AMP_BITS, 6, per-voice amplitude width; a voice at high level contributes 2^AMP_BITS-1 (63).
- PWM_BITS, 8, sample/duty/PWM counter width; must equal AMP_BITS+2 so the 4-voice sum cannot overflow.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- freq1  in  FREQ_WIDTH  voice 1 half-period in clocks; 0 = silent.
- freq2  in  FREQ_WIDTH  voice 2 half-period; 0 = silent.
- freq3  in  FREQ_WIDTH  voice 3 half-period; 0 = silent.
- freq4  in  FREQ_WIDTH  voice 4 half-period; 0 = silent.
- sample  out  PWM_BITS  registered mixed sample currently used as the PWM duty.
- sample_strobe  out  1  one-cycle pulse when `sample` loads a new value.
- pwm_out  out  1  registered PWM audio output.

Behaviour:
- Reset: all state clears on the clk edge while reset==0.
  - Cleared: voice counters, voice levels, freq_prev copies, the mix register, sample, the PWM counter, pwm_out and sample_strobe.
  - Reset overrides every other event, including mid-period operation.
- Voice i, checked in priority order each clk edge:
  - freq_i==0: counter<=0, level<=0, freq_prev<=0.
  - Else if freq_i!=freq_prev: counter<=0, level<=1, freq_prev<=freq_i. This is a phase restart, and it also applies when a voice goes from silent to sounding.
  - Else if counter==freq_i-1: counter<=0, level toggles.
  - Else counter<=counter+1.
  - Result: level high for freq_i cycles, then low for freq_i cycles. freq_i=1 gives a 2-cycle period; 4095 is the maximum.
- Mix:
  - mix <= sum over the four voices of (level ? 2^AMP_BITS-1 : 0), registered every cycle.
  - Width is PWM_BITS with no saturation needed; maximum 252.
- Latency: a freq change at edge N sets the level at edge N+1, which reaches mix at edge N+2.
- PWM counter (pcnt):
  - Free-runs 0..2^PWM_BITS-1 and wraps to 0.
  - When pcnt==2^PWM_BITS-1: sample<=mix and sample_strobe<=1. sample_strobe is 0 on every other cycle.
- pwm_out <= (pcnt < sample) each cycle, so the output is high for `sample` cycles out of 256.
  - sample=0: pwm_out never high.
  - sample=252: pwm_out high 252 of 256 cycles.
- Simultaneous events:
  - A freq change on a PWM-boundary edge is reflected in `sample` no earlier than the following boundary.
  - Changing several voices in the same cycle restarts each changed voice independently; unchanged voices keep their phase.

Optional Feature:
- Macro: TONE_MIXER_MUTE_EN.
- Defined:
  - Adds input port `mute` (4 bits, bit i-1 mutes voice i).
  - A muted voice contributes 0 to mix, but its counter and level keep running, so phase is preserved on unmute.
  - Mute takes effect in mix one cycle after it is applied.
- Undefined: no `mute` port; every voice always contributes.

Decomposition:
- Shared include sound_defs.vh holds:
  - NUM_VOICES=4
  - default FREQ_WIDTH, AMP_BITS and PWM_BITS values
  - the voice-amplitude constant 2^AMP_BITS-1
- Sub-module tone_voice:
  - Parameter: FREQ_WIDTH.
  - Ports: clk, reset, freq, level.
  - Contains the counter, freq_prev and level logic.
  - Instantiated four times; the top holds the mix, PWM counter and duty logic.

Test Plan:
1. Reset low 3 cycles, all freq=0, then release. Required:
   - pwm_out stays 0.
   - sample_strobe pulses every 256 cycles.
   - sample=0.
2. freq1=3, others 0. Required:
   - voice1 level high 3 / low 3 cycles.
   - mix alternates 63/0 with 2-cycle latency from the freq change.
   - each latched `sample` is 0 or 63.
3. All freq=1000, set in the same cycle. Required:
   - mix=252 for 1000 cycles, then 0 for 1000.
   - a PWM period latched during the high phase shows pwm_out high exactly 252 of 256 cycles.
4. freq1=100 steady, then changed to 50 mid-phase. Required:
   - level goes high the next edge.
   - first toggle occurs exactly 50 cycles later.
5. Reset pulled low mid-operation with all freq=1000. Required:
   - next edge: pwm_out=0, sample=0, sample_strobe=0.
   - after release: voices restart high, and the first strobe arrives 256 cycles later.
6. With TONE_MIXER_MUTE_EN: all freq=1000 and mute=4'b0001. Required:
   - mix=189 during the high phase.
   - clearing mute returns mix to 252 one cycle later, with no phase jump.

Source files
------------

// File: rtl/tone_mixer_pwm_pkg.sv
// tone_mixer_pwm_pkg
// Shared constants for the tone mixer: voice count, default widths and the
// per-voice amplitude helper.
package tone_mixer_pwm_pkg;

    localparam int unsigned NUM_VOICES     = 4;
    localparam int unsigned DEF_FREQ_WIDTH = 12;
    localparam int unsigned DEF_AMP_BITS   = 6;
    localparam int unsigned DEF_PWM_BITS   = 8;

    // Value a voice contributes to the mix while its level is high.
    function automatic int unsigned voice_amp(input int unsigned amp_bits);
        return (1 << amp_bits) - 1;
    endfunction

    localparam int unsigned VOICE_AMP = voice_amp(DEF_AMP_BITS);

endpackage

// File: rtl/tone_mixer_pwm_voice.sv
// tone_voice
// One square-wave voice: level is high for `freq` cycles, then low for `freq`
// cycles. freq==0 silences the voice; any change of freq restarts the phase
// with the level high.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-low reset
//   freq   in   half-period in clocks, 0 = silent
//   level  out  current voice level
module tone_voice #(
    parameter int unsigned FREQ_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FREQ_WIDTH-1:0] freq,
    output logic                  level
);

    logic [FREQ_WIDTH-1:0] cnt_q, cnt_d;
    logic [FREQ_WIDTH-1:0] freq_prev_q, freq_prev_d;
    logic                  level_q, level_d;

    always_comb begin
        cnt_d       = cnt_q;
        freq_prev_d = freq_prev_q;
        level_d     = level_q;
        if (freq == '0) begin
            cnt_d       = '0;
            level_d     = 1'b0;
            freq_prev_d = '0;
        end else if (freq != freq_prev_q) begin
            // Phase restart, also covers silent -> sounding.
            cnt_d       = '0;
            level_d     = 1'b1;
            freq_prev_d = freq;
        end else if (cnt_q == freq - FREQ_WIDTH'(1)) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + FREQ_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            freq_prev_q <= '0;
            level_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            freq_prev_q <= freq_prev_d;
            level_q     <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/tone_mixer_pwm.sv
// tone_mixer_pwm
// Mixes four square-wave voices into an unsigned sample and drives a 1-bit
// PWM output whose duty is refreshed once per 2^PWM_BITS-cycle period.
// Optional feature: define TONE_MIXER_MUTE_EN to add the per-voice `mute` input.
// Ports:
//   clk            in   system clock
//   reset          in   synchronous active-low reset
//   freq1..freq4   in   voice half-periods in clocks, 0 = silent
//   mute           in   (TONE_MIXER_MUTE_EN only) bit i-1 mutes voice i
//   sample         out  mixed sample currently used as PWM duty
//   sample_strobe  out  one-cycle pulse when sample loads
//   pwm_out        out  registered PWM audio output
module tone_mixer_pwm
    import tone_mixer_pwm_pkg::*;
#(
    parameter int unsigned FREQ_WIDTH = DEF_FREQ_WIDTH,
    parameter int unsigned AMP_BITS   = DEF_AMP_BITS,
    parameter int unsigned PWM_BITS   = DEF_PWM_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FREQ_WIDTH-1:0] freq1,
    input  logic [FREQ_WIDTH-1:0] freq2,
    input  logic [FREQ_WIDTH-1:0] freq3,
    input  logic [FREQ_WIDTH-1:0] freq4,
`ifdef TONE_MIXER_MUTE_EN
    input  logic [NUM_VOICES-1:0] mute,
`endif
    output logic [PWM_BITS-1:0]   sample,
    output logic                  sample_strobe,
    output logic                  pwm_out
);

    localparam logic [PWM_BITS-1:0] AMP = PWM_BITS'(voice_amp(AMP_BITS));

    logic [FREQ_WIDTH-1:0] freq_v [NUM_VOICES];
    logic [NUM_VOICES-1:0] level_v;
    logic [NUM_VOICES-1:0] mute_v;

    logic [PWM_BITS-1:0] mix_q, mix_d;
    logic [PWM_BITS-1:0] sample_q, sample_d;
    logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
    logic                strobe_q, strobe_d;
    logic                pwm_q, pwm_d;

    always_comb begin
        freq_v[0] = freq1;
        freq_v[1] = freq2;
        freq_v[2] = freq3;
        freq_v[3] = freq4;
    end

`ifdef TONE_MIXER_MUTE_EN
    assign mute_v = mute;
`else
    assign mute_v = '0;
`endif

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        tone_voice #(
            .FREQ_WIDTH(FREQ_WIDTH)
        ) u_voice (
            .clk  (clk),
            .reset(reset),
            .freq (freq_v[g]),
            .level(level_v[g])
        );
    end

    always_comb begin
        mix_d = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (level_v[i] && !mute_v[i]) begin
                mix_d = mix_d + AMP;
            end
        end
    end

    // The duty only changes on the last count of a PWM period, so every
    // period is generated from a single sample value.
    always_comb begin
        pcnt_d   = pcnt_q + PWM_BITS'(1);
        strobe_d = (pcnt_q == '1);
        sample_d = strobe_d ? mix_q : sample_q;
        pwm_d    = (pcnt_q < sample_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mix_q    <= '0;
            sample_q <= '0;
            pcnt_q   <= '0;
            strobe_q <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            mix_q    <= mix_d;
            sample_q <= sample_d;
            pcnt_q   <= pcnt_d;
            strobe_q <= strobe_d;
            pwm_q    <= pwm_d;
        end
    end

    assign sample        = sample_q;
    assign sample_strobe = strobe_q;
    assign pwm_out       = pwm_q;

endmodule

// File: tb/tb_tone_mixer_pwm.sv
// tb_tone_mixer_pwm
// Directed bench for tone_mixer_pwm. Cycle index `cyc` counts rising edges
// since reset release; all values are sampled 1 time unit after the edge.
module tb_tone_mixer_pwm;

    logic        clk;
    logic        reset;
    logic [11:0] freq1, freq2, freq3, freq4;
    logic [3:0]  mute;
    logic [7:0]  sample;
    logic        sample_strobe;
    logic        pwm_out;

    int unsigned n_checks;
    int unsigned n_errors;
    int unsigned cyc;

    tone_mixer_pwm #(
        .FREQ_WIDTH(12),
        .AMP_BITS  (6),
        .PWM_BITS  (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .freq1        (freq1),
        .freq2        (freq2),
        .freq3        (freq3),
        .freq4        (freq4),
`ifdef TONE_MIXER_MUTE_EN
        .mute         (mute),
`endif
        .sample       (sample),
        .sample_strobe(sample_strobe),
        .pwm_out      (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for 3 edges, then release with the given voices applied.
    task automatic start(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] d);
        reset = 1'b0;
        freq1 = '0; freq2 = '0; freq3 = '0; freq4 = '0;
        repeat (3) tick();
        reset = 1'b1;
        freq1 = a; freq2 = b; freq3 = c; freq4 = d;
        cyc   = 0;
    endtask

    initial begin
        int unsigned n_hi, n_hi2, n_stb, first;
        logic [11:0] pat;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        reset    = 1'b0;
        mute     = '0;
        freq1 = '0; freq2 = '0; freq3 = '0; freq4 = '0;

        // Reset state and idle operation.
        repeat (3) tick();
        check_eq("rst_pwm", pwm_out, 0);
        check_eq("rst_sample", sample, 0);
        check_eq("rst_strobe", sample_strobe, 0);
        check_eq("rst_mix", dut.mix_q, 0);
        reset = 1'b1;
        cyc = 0; n_hi = 0; n_stb = 0; first = 0;
        repeat (512) begin
            tick();
            if (pwm_out) n_hi++;
            if (sample_strobe) begin
                n_stb++;
                if (first == 0) first = cyc;
            end
        end
        check_eq("idle_pwm_high", n_hi, 0);
        check_eq("idle_strobes", n_stb, 2);
        check_eq("idle_first_strobe", first, 256);
        check_eq("idle_sample", sample, 0);

        // All four voices at 1000, set together.
        start(12'd1000, 12'd1000, 12'd1000, 12'd1000);
        n_hi = 0; n_hi2 = 0;
        repeat (2002) begin
            tick();
            if (cyc == 1)    check_eq("all_mix_c1", dut.mix_q, 0);
            if (cyc == 2)    check_eq("all_mix_c2", dut.mix_q, 252);
            if (cyc == 255)  check_eq("all_strobe_c255", sample_strobe, 0);
            if (cyc == 256) begin
                check_eq("all_strobe_c256", sample_strobe, 1);
                check_eq("all_sample_c256", sample, 252);
            end
            if (cyc >= 257 && cyc <= 512 && pwm_out) n_hi++;
            if (cyc == 768)  check_eq("all_sample_c768", sample, 252);
            if (cyc == 1001) check_eq("all_mix_c1001", dut.mix_q, 252);
            if (cyc == 1002) check_eq("all_mix_c1002", dut.mix_q, 0);
            if (cyc == 1024) check_eq("all_sample_c1024", sample, 0);
            if (cyc >= 1025 && cyc <= 1280 && pwm_out) n_hi2++;
            if (cyc == 2001) check_eq("all_mix_c2001", dut.mix_q, 0);
            if (cyc == 2002) check_eq("all_mix_c2002", dut.mix_q, 252);
        end
        check_eq("all_pwm_high_252", n_hi, 252);
        check_eq("all_pwm_high_0", n_hi2, 0);

        // Single voice, half-period 3.
        start(12'd3, 12'd0, 12'd0, 12'd0);
        pat = '0;
        repeat (512) begin
            tick();
            if (cyc <= 12) pat[12 - cyc] = (dut.mix_q == 8'd63);
            if (cyc == 256) check_eq("v3_sample_c256", sample, 63);
            if (cyc == 512) check_eq("v3_sample_c512", sample, 0);
        end
        check_eq("v3_mix_pattern", pat, 12'b011100011100);

        // Half-period 100, changed to 50 mid low phase.
        start(12'd100, 12'd0, 12'd0, 12'd0);
        repeat (202) begin
            tick();
            if (cyc == 101) check_eq("chg_mix_c101", dut.mix_q, 63);
            if (cyc == 102) check_eq("chg_mix_c102", dut.mix_q, 0);
            if (cyc == 150) freq1 = 12'd50;
            if (cyc == 151) check_eq("chg_mix_c151", dut.mix_q, 0);
            if (cyc == 152) check_eq("chg_mix_c152", dut.mix_q, 63);
            if (cyc == 201) check_eq("chg_mix_c201", dut.mix_q, 63);
            if (cyc == 202) check_eq("chg_mix_c202", dut.mix_q, 0);
        end

        // Reset in mid-operation.
        start(12'd1000, 12'd1000, 12'd1000, 12'd1000);
        repeat (600) tick();
        check_eq("mid_pre_pwm", pwm_out, 1);
        check_eq("mid_pre_sample", sample, 252);
        reset = 1'b0;
        tick();
        check_eq("mid_rst_pwm", pwm_out, 0);
        check_eq("mid_rst_sample", sample, 0);
        check_eq("mid_rst_strobe", sample_strobe, 0);
        check_eq("mid_rst_mix", dut.mix_q, 0);
        repeat (2) tick();
        reset = 1'b1;
        cyc = 0; first = 0;
        repeat (300) begin
            tick();
            if (cyc == 2) check_eq("mid_rel_mix_c2", dut.mix_q, 252);
            if (sample_strobe && first == 0) first = cyc;
        end
        check_eq("mid_rel_first_strobe", first, 256);

`ifdef TONE_MIXER_MUTE_EN
        // Voice 1 muted, then unmuted without phase disturbance.
        mute = 4'b0001;
        start(12'd1000, 12'd1000, 12'd1000, 12'd1000);
        repeat (1002) begin
            tick();
            if (cyc == 2)  check_eq("mute_mix_c2", dut.mix_q, 189);
            if (cyc == 10) begin
                check_eq("mute_mix_c10", dut.mix_q, 189);
                mute = 4'b0000;
            end
            if (cyc == 11)   check_eq("mute_mix_c11", dut.mix_q, 252);
            if (cyc == 1001) check_eq("mute_mix_c1001", dut.mix_q, 252);
            if (cyc == 1002) check_eq("mute_mix_c1002", dut.mix_q, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
